fifo_rr_ctrl: RTL

Controller that shares one fifo instance between NUM_REQ producers and one downstream consumer.
- Write side: round-robin arbitration among producer valid/ready channels; drives the fifo push/data inputs.
- Read side: sequences fifo pops and presents the data as a valid/ready stream.
- Also owns flushing and keeps an occupancy count used for gating and status.

---
 rtl/fifo_rr_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fifo_rr_ctrl.sv
// Shares one fifo between NUM_REQ round-robin producers and one valid/ready consumer.
// Owns flush sequencing and the occupancy count that gates push and pop.
//
// state       | meaning
// ST_IDLE     | no word in flight; pop as soon as the fifo holds data
// ST_FETCH    | pop issued last cycle; fifo_dout_i is captured this cycle
// ST_VALID    | m_data_o presented, held until m_ready_i
module fifo_rr_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          flush_req_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
  output logic                          fifo_pop_o,
  output logic                          fifo_flush_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]         fifo_dout_i,
  output logic                          m_valid_o,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  input  logic                          m_ready_i,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic [CNT_WIDTH-1:0]          occupancy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } rd_state_e;

  localparam logic [CNT_WIDTH-1:0] DEPTH   = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [ID_WIDTH-1:0]  LAST_ID = ID_WIDTH'(NUM_REQ - 1);

  rd_state_e             state_q, state_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;

  logic                  win_found;
  logic [ID_WIDTH-1:0]   win_id;
  logic [ID_WIDTH-1:0]   cand_id;
  int unsigned           cand;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  push_en;
  logic                  pop_en;
  logic                  can_pop;

  // Search starts one past the last grant so every producer gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = grant_q;
    cand      = 0;
    cand_id   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(grant_q) + k) % NUM_REQ;
      cand_id = ID_WIDTH'(cand);
      if (!win_found && req_valid_i[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == win_id) win_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Push gating uses only registered occupancy, keeping m_ready_i off the req_ready path.
  assign push_en     = rst_n & ~flush_req_i & (occ_q < DEPTH) & ~fifo_full_i & win_found;
  assign req_ready_o = push_en ? (NUM_REQ'(1) << win_id) : '0;
  assign fifo_push_o = push_en;
  assign fifo_din_o  = win_data;
  assign grant_d     = push_en ? win_id : grant_q;

  assign can_pop = (occ_q != '0) & ~fifo_empty_i;

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    pop_en    = 1'b0;
    if (flush_req_i) begin
      state_d   = ST_IDLE;
      m_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (can_pop) begin
            pop_en  = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          m_data_d  = fifo_dout_i;
          m_valid_d = 1'b1;
          state_d   = ST_VALID;
        end
        ST_VALID: begin
          if (m_ready_i) begin
            m_valid_d = 1'b0;
            if (can_pop) begin
              pop_en  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign fifo_pop_o   = rst_n & pop_en;
  assign fifo_flush_o = rst_n & flush_req_i;

  always_comb begin
    occ_d = occ_q;
    if (flush_req_i) begin
      occ_d = '0;
    end else begin
      case ({push_en, pop_en})
        2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
        2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      occ_q     <= '0;
      grant_q   <= LAST_ID;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      occ_q     <= occ_d;
      grant_q   <= grant_d;
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign grant_id_o  = grant_q;
  assign occupancy_o = occ_q;

endmodule
